// File: rtl/mac_unit_if.sv
// Bus bundle for the sign-magnitude MAC: operand inputs, accumulate enable,
// accumulator value and sticky overflow flag.
interface mac_unit_if #(
    parameter int unsigned N = 32
);
    logic         en;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] out;
    logic         ovr;

    modport master (output en, output A, output B, input out, input ovr);
    modport slave  (input en, input A, input B, output out, output ovr);
endinterface

// File: rtl/mac_unit.sv
// Sign-magnitude Q-format multiply-accumulate element with saturating,
// sticky-flagged overflow and one-cycle latency.
module mac_unit #(
    parameter int unsigned Q = 10,
    parameter int unsigned N = 32
) (
    input  logic     clk,
    input  logic     rst,
    mac_unit_if.slave bus
);
    localparam int unsigned M  = N - 1;   // magnitude width
    localparam int unsigned PW = 2 * M;   // full product width

    logic [M-1:0]  a_mag;
    logic [M-1:0]  b_mag;
    logic [M-1:0]  s_mag;
    logic          s_sign;
    logic [PW-1:0] full;
    logic [PW-1:0] scaled;
    logic          p_sign;
    logic          p_ovf;
    logic [M-1:0]  p_mag;
    logic [M:0]    sum;
    logic          add_ovf;
    logic [M-1:0]  r_mag;
    logic          r_sign;

    logic [N-1:0]  acc;
    logic          ovr_q;

    // Multiply, rescale to Q and saturate the product magnitude.
    always_comb begin
        a_mag  = bus.A[M-1:0];
        b_mag  = bus.B[M-1:0];
        p_sign = bus.A[N-1] ^ bus.B[N-1];
        full   = PW'(a_mag) * PW'(b_mag);
        scaled = full >> Q;
        p_ovf  = |scaled[PW-1:M];
        p_mag  = p_ovf ? {M{1'b1}} : scaled[M-1:0];
    end

    // Sign-magnitude add of product onto the accumulator; a zero result is
    // always stored as positive zero.
    always_comb begin
        s_mag   = acc[M-1:0];
        s_sign  = acc[N-1];
        sum     = (M+1)'(p_mag) + (M+1)'(s_mag);
        add_ovf = 1'b0;
        r_mag   = s_mag;
        r_sign  = s_sign;
        if (p_sign == s_sign) begin
            add_ovf = sum[M];
            r_mag   = sum[M] ? {M{1'b1}} : sum[M-1:0];
            r_sign  = s_sign;
        end else if (p_mag > s_mag) begin
            r_mag  = p_mag - s_mag;
            r_sign = p_sign;
        end else begin
            r_mag  = s_mag - p_mag;
            r_sign = s_sign;
        end
        if (r_mag == '0) begin
            r_sign = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ovr_q <= 1'b0;
        end else if (bus.en) begin
            acc   <= {r_sign, r_mag};
            ovr_q <= ovr_q | p_ovf | add_ovf;
        end
    end

    assign bus.out = acc;
    assign bus.ovr = ovr_q;
endmodule

// File: tb/tb_mac_unit.sv
// Directed self-checking bench for mac_unit with hand-computed Q22.10 values.
module tb_mac_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mac_unit_if #(.N(32)) bus ();

    mac_unit #(.Q(10), .N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fx(input logic s, input int unsigned ip, input int unsigned fr);
        return {s, 21'(ip), 10'(fr)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ovr(input string tag, input logic exp);
        checks++;
        assert (bus.ovr === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, bus.ovr, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic mac(input logic [31:0] a, input logic [31:0] b);
        bus.A  = a;
        bus.B  = b;
        bus.en = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        bus.en = 1'b0;
        bus.A  = '0;
        bus.B  = '0;

        // Reset state
        do_reset();
        check("reset_out", bus.out, 32'd0);
        check_ovr("reset_ovr", 1'b0);

        // Positive integers
        mac(fx(0, 1, 0), fx(0, 2, 0)); check("int_1x2", bus.out, fx(0, 2, 0));
        mac(fx(0, 3, 0), fx(0, 2, 0)); check("int_3x2", bus.out, fx(0, 8, 0));
        mac(fx(0, 5, 0), fx(0, 5, 0)); check("int_5x5", bus.out, fx(0, 33, 0));

        // Mixed signs, accumulator stays positive
        do_reset();
        mac(fx(0, 5, 0), fx(0, 8, 0)); check("mix_5x8",   bus.out, fx(0, 40, 0));
        mac(fx(0, 2, 0), fx(0, 3, 0)); check("mix_2x3",   bus.out, fx(0, 46, 0));
        mac(fx(1, 3, 0), fx(0, 4, 0)); check("mix_n3x4",  bus.out, fx(0, 34, 0));
        mac(fx(1, 2, 0), fx(1, 2, 0)); check("mix_n2xn2", bus.out, fx(0, 38, 0));

        // Sign crossing
        do_reset();
        mac(fx(1, 1, 0), fx(1, 1, 0));  check("cross_n1xn1", bus.out, fx(0, 1, 0));
        mac(fx(0, 5, 0), fx(1, 8, 0));  check("cross_5xn8",  bus.out, fx(1, 39, 0));
        mac(fx(0, 2, 0), fx(1, 3, 0));  check("cross_2xn3",  bus.out, fx(1, 45, 0));
        mac(fx(0, 5, 0), fx(0, 10, 0)); check("cross_5x10",  bus.out, fx(0, 5, 0));

        // Fractions and truncation
        do_reset();
        mac(fx(0, 0, 512), fx(0, 0, 512));  check("frac_half_sq",  bus.out, fx(0, 0, 256));
        mac(fx(0, 0, 256), fx(0, 1, 512));  check("frac_q_x_1p5",  bus.out, fx(0, 0, 640));
        mac(fx(1, 5, 96), fx(0, 3, 256));   check("frac_neg",      bus.out, fx(1, 15, 952));
        mac(fx(1, 2, 256), fx(0, 0, 0));    check("frac_times_0",  bus.out, fx(1, 15, 952));
        mac(fx(0, 0, 1), fx(0, 0, 512));    check("frac_trunc_0",  bus.out, fx(1, 15, 952));
        mac(fx(1, 3, 0), fx(1, 0, 0));      check("neg_zero_op",   bus.out, fx(1, 15, 952));

        // Hold with en low while inputs move
        for (int i = 0; i < 3; i++) begin
            bus.A = fx(0, 7 + i, 0);
            bus.B = fx(1, 9, 0);
            @(posedge clk); #1;
            check("hold_out", bus.out, fx(1, 15, 952));
        end

        // Cancellation yields positive zero
        do_reset();
        mac(fx(0, 1, 0), fx(0, 2, 0)); check("zero_pre", bus.out, fx(0, 2, 0));
        mac(fx(0, 2, 0), fx(1, 1, 0)); check("zero_sum", bus.out, 32'd0);

        // Product overflow saturates and sets sticky flag
        do_reset();
        mac(fx(0, 1 << 20, 0), fx(0, 1 << 20, 0));
        check("ovf_out", bus.out, 32'h7FFF_FFFF);
        check_ovr("ovf_flag", 1'b1);
        mac(fx(0, 1, 0), fx(0, 1, 0));
        check("ovf_addsat", bus.out, 32'h7FFF_FFFF);
        mac(fx(1, 1, 0), fx(0, 1, 0));
        check("ovf_sub", bus.out, 32'h7FFF_FBFF);
        check_ovr("ovf_sticky", 1'b1);
        @(posedge clk); #1;
        check_ovr("ovf_hold", 1'b1);

        // Reset wins over enable
        bus.en = 1'b1;
        bus.A  = fx(0, 3, 0);
        bus.B  = fx(0, 3, 0);
        rst    = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        bus.en = 1'b0;
        check("rst_pri_out", bus.out, 32'd0);
        check_ovr("rst_pri_ovr", 1'b0);
        mac(fx(0, 3, 0), fx(0, 3, 0)); check("restart", bus.out, fx(0, 9, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
